// File: rtl/dmem_bus_pkg.sv
// Shared types and constants for the data-memory bus arbiter.
package dmem_bus_pkg;
  typedef enum logic [2:0] {IDLE, RD, WR, WACK, RESP} state_t;

  localparam logic [31:0] MEM_ERR_RDATA = 32'h0;
  localparam logic        M_CPU         = 1'b0;
  localparam logic        M_DMA         = 1'b1;
endpackage

// File: rtl/dmem_bus_arbiter_rr_pick2.sv
// Combinational 2-way round-robin pick; prio names the master that wins a tie.
module rr_pick2
  import dmem_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic       gnt_idx,
  output logic       gnt_valid
);
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = M_CPU;
    if (req == 2'b11) gnt_idx = prio;
    else if (req[1])  gnt_idx = M_DMA;
  end
endmodule

// File: rtl/dmem_bus_arbiter.sv
// Two-master arbiter/sequencer for the data-memory port: latches one transaction,
// drives the read/write handshake, and returns done/err/rdata to the owner.
module dmem_bus_arbiter
  import dmem_bus_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_read_acc,
  input  logic        mem_write_acc
);
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t           state;
  logic             owner;
  logic             prio;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [CW-1:0]    cnt;
  logic [1:0]       done_q;
  logic [1:0]       err_q;
  logic [1:0][31:0] rdata_q;
  logic             gnt_idx;
  logic             gnt_valid;

  rr_pick2 u_pick (
    .req       ({m1_req, m0_req}),
    .prio      (prio),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Strobes decode straight from state so a write strobe can never outlive WR.
  assign mem_read  = (state == RD);
  assign mem_write = (state == WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign m0_done  = done_q[0];
  assign m1_done  = done_q[1];
  assign m0_err   = err_q[0];
  assign m1_err   = err_q[1];
  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      owner   <= M_CPU;
      prio    <= M_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner   <= gnt_idx;
            prio    <= ~gnt_idx;
            we_q    <= gnt_idx ? m1_we    : m0_we;
            addr_q  <= gnt_idx ? m1_addr  : m0_addr;
            wdata_q <= gnt_idx ? m1_wdata : m0_wdata;
            cnt     <= '0;
            state   <= (gnt_idx ? m1_we : m0_we) ? WR : RD;
          end
        end
        RD: begin
          if (mem_read_acc) begin
            done_q[owner]  <= 1'b1;
            rdata_q[owner] <= mem_rdata;
            state          <= RESP;
          end else if (cnt == CNT_LAST) begin
            done_q[owner]  <= 1'b1;
            err_q[owner]   <= 1'b1;
            rdata_q[owner] <= MEM_ERR_RDATA;
            state          <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR: begin
          cnt   <= '0;
          state <= WACK;
        end
        WACK: begin
          if (mem_write_acc || cnt == CNT_LAST) begin
            done_q[owner]  <= 1'b1;
            err_q[owner]   <= ~mem_write_acc;
            rdata_q[owner] <= MEM_ERR_RDATA;
            state          <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Bench for dmem_bus_arbiter: transaction-timeline model plus directed literal pins.
module tb_dmem_bus_arbiter;
  localparam int T = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic        m0_done, m1_done, m0_err, m1_err;
  logic        mem_read, mem_write, mem_read_acc, mem_write_acc;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  logic        r_req[2];
  logic        r_we[2];
  logic [31:0] r_addr[2];
  logic [31:0] r_wdata[2];
  assign m0_req = r_req[0];   assign m1_req = r_req[1];
  assign m0_we = r_we[0];     assign m1_we = r_we[1];
  assign m0_addr = r_addr[0]; assign m1_addr = r_addr[1];
  assign m0_wdata = r_wdata[0]; assign m1_wdata = r_wdata[1];

  dmem_bus_arbiter #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read_acc(mem_read_acc), .mem_write_acc(mem_write_acc)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: a granted transaction is a timeline fixed at the grant edge.
  int          e = 0, st = 0, free_edge = -1;
  bit          in_reset, rnd_en, prio_m, use_fixed;
  bit          hold[2];
  int          force_L;
  logic [31:0] fixed_rdata;
  bit          tr_valid, tr_we, tr_err;
  int          tr_own, tr_E, tr_n, tr_L, tr_done;
  logic [31:0] tr_addr, tr_wdata, tr_rdata;
  bit          in_rd, in_wack;

  // Observation log
  int          obs_rd, obs_wr, last_done_st;
  int          done_cnt[2];
  logic        last_err;
  logic [31:0] last_rdata;
  int          owners[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, e, act, exp);
    end
  endtask

  task automatic new_params(input int m);
    logic [31:0] a;
    a = $urandom;
    a[1:0] = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    r_we[m]    = 1'($urandom_range(0, 1));
    r_addr[m]  = a;
    r_wdata[m] = $urandom;
  endtask

  task automatic step();
    bit exp_rd, exp_wr, keep;
    bit exp_done[2];
    @(posedge clk);
    e++; st++;
    if (!in_reset && e == free_edge) begin
      if (r_req[0] || r_req[1]) begin
        tr_own   = (r_req[0] && r_req[1]) ? int'(prio_m) : (r_req[1] ? 1 : 0);
        prio_m   = (tr_own == 0);
        tr_we    = r_we[tr_own];
        tr_addr  = r_addr[tr_own];
        tr_wdata = r_wdata[tr_own];
        if (force_L >= 0) tr_L = force_L;
        else begin
          int r;
          r = $urandom_range(0, 9);
          tr_L = (r < 7) ? $urandom_range(0, 3) : (r < 9) ? $urandom_range(4, T - 1) : T;
        end
        if (tr_addr[1:0] != 2'b00) tr_L = T;
        tr_err    = (tr_L >= T);
        tr_n      = tr_err ? T : tr_L + 1;
        tr_E      = e;
        tr_done   = tr_we ? e + tr_n + 1 : e + tr_n;
        free_edge = tr_done + 2;
        tr_rdata  = 32'h0;
        tr_valid  = 1'b1;
      end else begin
        free_edge = e + 1;
      end
    end
    #1;
    in_rd   = tr_valid && !tr_we && e >= tr_E && e < tr_E + tr_n;
    in_wack = tr_valid && tr_we && e > tr_E && e <= tr_E + tr_n;
    mem_rdata = use_fixed ? fixed_rdata : $urandom;
    if (in_reset) begin
      mem_read_acc  = 1'b0;
      mem_write_acc = 1'b0;
    end else begin
      if (in_rd) begin
        mem_read_acc = !tr_err && (e == tr_E + tr_L);
        if (mem_read_acc) tr_rdata = mem_rdata;
      end else mem_read_acc = 1'($urandom_range(0, 1));
      if (in_wack) mem_write_acc = !tr_err && (e == tr_E + 1 + tr_L);
      else         mem_write_acc = 1'($urandom_range(0, 1));
    end

    @(negedge clk);
    exp_rd = in_rd;
    exp_wr = tr_valid && tr_we && e == tr_E;
    for (int m = 0; m < 2; m++) exp_done[m] = tr_valid && e == tr_done && tr_own == m;
    chk("mem_read", 32'(mem_read), 32'(exp_rd));
    chk("mem_write", 32'(mem_write), 32'(exp_wr));
    chk("m0_done", 32'(m0_done), 32'(exp_done[0]));
    chk("m1_done", 32'(m1_done), 32'(exp_done[1]));
    chk("m0_err", 32'(m0_err), 32'(exp_done[0] && tr_err));
    chk("m1_err", 32'(m1_err), 32'(exp_done[1] && tr_err));
    if (exp_rd || exp_wr) chk("mem_addr", mem_addr, tr_addr);
    if (exp_wr) chk("mem_wdata", mem_wdata, tr_wdata);
    if (exp_done[0] && !tr_we) chk("m0_rdata", m0_rdata, tr_err ? 32'h0 : tr_rdata);
    if (exp_done[1] && !tr_we) chk("m1_rdata", m1_rdata, tr_err ? 32'h0 : tr_rdata);

    obs_rd += int'(mem_read);
    obs_wr += int'(mem_write);
    if (m0_done) begin
      done_cnt[0]++; owners.push_back(0);
      last_done_st = st; last_err = m0_err; last_rdata = m0_rdata;
    end
    if (m1_done) begin
      done_cnt[1]++; owners.push_back(1);
      last_done_st = st; last_err = m1_err; last_rdata = m1_rdata;
    end

    if (!in_reset) begin
      for (int m = 0; m < 2; m++) begin
        if (tr_valid && e == tr_done && tr_own == m) begin
          keep = rnd_en ? 1'($urandom_range(0, 1)) : hold[m];
          r_req[m] = keep;
          if (keep && rnd_en) new_params(m);
        end else if (tr_valid && e < tr_done && tr_own == m) begin
          if (rnd_en) new_params(m);
        end else if (rnd_en && !r_req[m] && $urandom_range(0, 3) == 0) begin
          r_req[m] = 1'b1;
          new_params(m);
        end
      end
    end
  endtask

  task automatic clear_obs();
    st = 0; obs_rd = 0; obs_wr = 0; last_done_st = -1;
    done_cnt[0] = 0; done_cnt[1] = 0;
    owners.delete();
  endtask

  task automatic run_until(input int n_done, input int budget, input string name);
    int b;
    b = budget;
    while (owners.size() < n_done && b > 0) begin
      step();
      b--;
    end
    if (owners.size() < n_done) begin
      n_cmp++; n_err++;
      $display("FAIL %s: timed out waiting, got %0d done pulses, expected %0d", name, owners.size(), n_done);
    end
  endtask

  task automatic drain();
    repeat (3) step();
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_mem_read"}, 32'(mem_read), 32'h0);
    chk({name, "_mem_write"}, 32'(mem_write), 32'h0);
    chk({name, "_mem_addr"}, mem_addr, 32'h0);
    chk({name, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({name, "_done"}, 32'({m1_done, m0_done}), 32'h0);
    chk({name, "_err"}, 32'({m1_err, m0_err}), 32'h0);
    chk({name, "_m0_rdata"}, m0_rdata, 32'h0);
    chk({name, "_m1_rdata"}, m1_rdata, 32'h0);
  endtask

  initial begin
    reset = 1'b0; in_reset = 1'b1; rnd_en = 1'b0; use_fixed = 1'b0; force_L = -1;
    prio_m = 1'b0; tr_valid = 1'b0; fixed_rdata = 32'h0;
    mem_read_acc = 1'b0; mem_write_acc = 1'b0; mem_rdata = 32'h0;
    for (int m = 0; m < 2; m++) begin
      r_req[m] = 1'b0; r_we[m] = 1'b0; r_addr[m] = 32'h0; r_wdata[m] = 32'h0; hold[m] = 1'b0;
    end
    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b1; in_reset = 1'b0; free_edge = e + 1;
    drain();

    // m0 read, immediate acknowledge
    clear_obs();
    use_fixed = 1'b1; fixed_rdata = 32'h1234_5678; force_L = 0;
    r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 32'h0000_0010;
    run_until(1, 20, "t1_wait");
    chk("t1_latency", 32'(last_done_st), 32'd2);
    chk("t1_rdata", last_rdata, 32'h1234_5678);
    chk("t1_err", 32'(last_err), 32'h0);
    drain();
    chk("t1_read_cycles", 32'(obs_rd), 32'd1);

    // m1 write, ack next cycle
    clear_obs();
    r_req[1] = 1'b1; r_we[1] = 1'b1; r_addr[1] = 32'h4000_000C; r_wdata[1] = 32'h0000_00A5;
    run_until(1, 20, "t2_wait");
    chk("t2_latency", 32'(last_done_st), 32'd3);
    chk("t2_owner", 32'(owners[0]), 32'd1);
    chk("t2_err", 32'(last_err), 32'h0);
    drain();
    chk("t2_write_cycles", 32'(obs_wr), 32'd1);

    // both masters hold req: strict alternation
    clear_obs();
    hold[0] = 1'b1; hold[1] = 1'b1;
    r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 32'h0000_0100;
    r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 32'h0000_0200;
    run_until(4, 60, "t3_wait");
    r_req[0] = 1'b0; r_req[1] = 1'b0; hold[0] = 1'b0; hold[1] = 1'b0;
    drain();
    if (owners.size() >= 4) begin
      int exp_own[4] = '{0, 1, 0, 1};
      for (int i = 0; i < 4; i++) chk("t3_owner", 32'(owners[i]), 32'(exp_own[i]));
    end
    chk("t3_m0_count", 32'(done_cnt[0]), 32'd2);
    chk("t3_m1_count", 32'(done_cnt[1]), 32'd2);

    // read timeout
    clear_obs();
    use_fixed = 1'b0; force_L = T;
    r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 32'h8000_0000;
    run_until(1, 40, "t4_wait");
    chk("t4_latency", 32'(last_done_st), 32'd16);
    chk("t4_err", 32'(last_err), 32'h1);
    chk("t4_rdata", last_rdata, 32'h0);
    drain();
    chk("t4_read_cycles", 32'(obs_rd), 32'(T));

    // randomized traffic against the model
    force_L = -1; rnd_en = 1'b1;
    repeat (3000) step();
    rnd_en = 1'b0; r_req[0] = 1'b0; r_req[1] = 1'b0;
    repeat (40) step();

    // reset during WACK after an m0 grant (priority then points at m1)
    clear_obs();
    force_L = T;
    r_req[0] = 1'b1; r_we[0] = 1'b1; r_addr[0] = 32'h0000_0300; r_wdata[0] = 32'h5A5A_5A5A;
    step(); step();
    reset = 1'b0; in_reset = 1'b1; tr_valid = 1'b0; prio_m = 1'b0;
    r_req[0] = 1'b0;
    #1;
    check_all_zero("t5_reset");
    step(); step();
    reset = 1'b1; in_reset = 1'b0; free_edge = e + 1;
    clear_obs();
    repeat (5) step();
    chk("t5_no_write", 32'(obs_wr), 32'h0);
    force_L = 0;
    r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 32'h0000_0400;
    r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 32'h0000_0500;
    run_until(1, 20, "t5_wait");
    if (owners.size() >= 1) chk("t5_first_owner", 32'(owners[0]), 32'd0);
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_bus_arbiter.md
# dmem_bus_arbiter

Two-master arbiter and transaction sequencer in front of the single data-memory/peripheral port. It shares the port between the CPU load/store unit (master 0) and the UART boot-loader/DMA engine (master 1). Each transaction is latched, the memory strobes are driven with the correct read/write handshake, and completion or timeout is reported back to the owning master. It sits between the CPU's MEM stage and the data memory block.

## Interface
- `TIMEOUT`, default 15: cycles to wait for an access acknowledge before aborting with error.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low.
- `m0_req` / `m1_req` in 1: transaction request, level. Held until `done`.
- `m0_we` / `m1_we` in 1: 1 = write, 0 = read.
- `m0_addr` / `m1_addr` in 32: byte address, word aligned.
- `m0_wdata` / `m1_wdata` in 32: write data.
- `m0_rdata` / `m1_rdata` out 32: read data. Valid while `done` is high.
- `m0_done` / `m1_done` out 1: one-cycle completion pulse.
- `m0_err` / `m1_err` out 1: qualifies `done`; transaction timed out.
- `mem_read` out 1: read strobe to the memory.
- `mem_write` out 1: write strobe to the memory.
- `mem_addr` out 32: address to the memory.
- `mem_wdata` out 32: write data to the memory.
- `mem_rdata` in 32: read data from the memory.
- `mem_read_acc` in 1: read acknowledge. Combinational, same cycle as `mem_read`.
- `mem_write_acc` in 1: write acknowledge. Registered, arrives the cycle after the write edge.

## Operation
- FSM states: IDLE, RD, WR, WACK, RESP.
- **IDLE**
  - If any request is present, the round-robin pick selects the owner.
  - `addr`, `we` and `wdata` of the owner are latched.
  - Next state is RD (`we`=0) or WR (`we`=1).
  - With no request, the FSM stays in IDLE.
- **Round-robin pick**
  - If only one master requests, it wins.
  - If both request, the master given by the priority bit wins.
  - After every grant, the priority bit points to the other master.
  - Reset sets the priority bit to master 0.
- **RD**
  - `mem_read`=1 for the whole state; `mem_addr` = latched address.
  - If `mem_read_acc`=1: capture `mem_rdata`, clear `err`, go to RESP.
  - Otherwise increment the timeout counter. When the counter reaches `TIMEOUT`: set rdata=0, `err`=1, go to RESP.
- **WR**
  - `mem_write`=1 for exactly one cycle. The strobe is never held, so peripheral side effects (UART TX) happen once.
  - Counter cleared; next state WACK.
- **WACK**
  - All strobes are 0.
  - If `mem_write_acc`=1: `err`=0, go to RESP.
  - Otherwise increment the counter; on reaching `TIMEOUT`: `err`=1, go to RESP.
- **RESP**
  - Owner's `done`=1 and `err` as captured; owner's `rdata` = captured data.
  - The other master's `done` and `err` stay 0.
  - Next state IDLE.
- **Requests after done**
  - A master still asserting `req` when the FSM is back in IDLE is treated as a new transaction.
  - A master that wants a single access drops `req` in the cycle after `done`.
- **Mid-transaction behaviour**
  - Requests arriving while the FSM is busy wait.
  - Changes to the owner's inputs mid-transaction are ignored, because the inputs are latched.
- **Timeout counter**
  - Width `$clog2(TIMEOUT+1)`; saturating is not needed because the FSM exits at `TIMEOUT`.
  - Cleared on entry to RD and WR.
- **Unaligned address** (`addr[1:0]`≠0): forwarded unchanged. The memory does not acknowledge, so the transaction times out with `err`.
- **Reset, including mid-transaction**
  - FSM returns to IDLE.
  - `mem_read`=`mem_write`=0; `mem_addr`=`mem_wdata`=0.
  - All `done`/`err`=0, all `rdata`=0, counter=0, priority bit=0.
  - No write is issued after reset release until a new request arrives.

## Timing
- Read with immediate acknowledge:
  - `req` sampled at edge 0 (IDLE).
  - RD in cycle 1.
  - `done` in cycle 2.
  - IDLE in cycle 3.
- Write:
  - WR in cycle 1.
  - WACK in cycle 2 (`mem_write_acc` seen).
  - `done` in cycle 3.
- Timeout: RD or WACK lasts `TIMEOUT` cycles before RESP.
- Back-to-back throughput: one read per 3 cycles and one write per 4 cycles.
- All outputs are registered, except `mem_*` strobes, address and data, which are decoded from state plus latched registers.

## Structure
- **Shared package `dmem_bus_pkg`**
  - State enum.
  - `MEM_ERR_RDATA` constant (32'h0).
  - Master index constants M_CPU=0 and M_DMA=1.
- **Sub-module `rr_pick2`**
  - Combinational 2-way round-robin selector.
  - Inputs: `req[1:0]`, `prio`.
  - Outputs: `gnt_idx`, `gnt_valid`.

## Test plan
- m0 reads 0x0000_0010 with `mem_read_acc`=1 and `mem_rdata`=0x1234_5678 → `mem_read` high for 1 cycle; `m0_done` in cycle 2 with `m0_rdata`=0x1234_5678 and `m0_err`=0.
- m1 writes 0x4000_000C with data 0xA5, `mem_write_acc` returned the next cycle → `mem_write` high for exactly 1 cycle; `m1_done` in cycle 3.
- Both masters hold `req` continuously → grants alternate m0, m1, m0, m1; each master gets exactly 2 `done` pulses in 4 transactions.
- m0 reads 0x8000_0000 with `mem_read_acc` stuck at 0 and `TIMEOUT`=15 → `m0_done` and `m0_err` both 1 after 15 RD cycles, with `m0_rdata`=0.
- `reset` asserted low during WACK → all outputs 0 at once; after release with no `req`, `mem_write` stays 0 and the next contended grant goes to m0.
